// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU arbiter: opcode encoding, arbiter FSM states and
// the last legal opcode.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_SRA = 4'd7
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam opcode_t OP_LAST = OP_SRA;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared ALU.
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if #(parameter int N = 8);

   logic         req0_valid;
   logic         req0_ready;
   logic [3:0]   req0_op;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic         req1_valid;
   logic         req1_ready;
   logic [3:0]   req1_op;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;

   logic         resp0_valid;
   logic         resp0_ready;
   logic [N-1:0] resp0_y;
   logic         resp0_flg;
   logic         resp0_err;
   logic         resp1_valid;
   logic         resp1_ready;
   logic [N-1:0] resp1_y;
   logic         resp1_flg;
   logic         resp1_err;

   logic [3:0]   alu_op;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [N-1:0] alu_y;
   logic         alu_flg;

   logic         busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_y, resp0_flg, resp0_err,
      output resp1_valid, resp1_y, resp1_flg, resp1_err,
      input  resp0_ready, resp1_ready,
      output alu_op, alu_a, alu_b,
      input  alu_y, alu_flg,
      output busy
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_y, resp0_flg, resp0_err,
      input  resp1_valid, resp1_y, resp1_flg, resp1_err,
      output resp0_ready, resp1_ready,
      input  alu_op, alu_a, alu_b,
      output alu_y, alu_flg,
      input  busy
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to prio.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt,
   output logic       idx
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = prio ? 2'b10 : 2'b01;
      end
      idx = gnt[1];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant.
// Optional opcode check: define ALU_ARB_OPCHK_EN.
//
//   state | meaning
//   IDLE  | waiting for a request; grant is offered on req*_ready
//   EXEC  | operands registered on the ALU bus, result captured at end
//   RESP  | result held on the winner's response channel until taken
module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int N = 8
) (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus
);

   arb_state_t   state_q, state_d;
   logic         prio_q;
   logic         g_q;
   logic [3:0]   op_q;
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic [N-1:0] res_y_q;
   logic         res_flg_q;
   logic         res_err_q;

   logic [1:0]   req_vec;
   logic [1:0]   gnt;
   logic         gnt_idx;
   logic [3:0]   sel_op;
   logic [N-1:0] sel_a;
   logic [N-1:0] sel_b;
   logic         accept;
   logic         illegal;
   logic         resp_take;

   assign req_vec = {bus.req1_valid, bus.req0_valid};

   rr_arb2 u_rr_arb2 (
      .req  (req_vec),
      .prio (prio_q),
      .gnt  (gnt),
      .idx  (gnt_idx)
   );

   always_comb begin
      sel_op    = gnt_idx ? bus.req1_op : bus.req0_op;
      sel_a     = gnt_idx ? bus.req1_a  : bus.req0_a;
      sel_b     = gnt_idx ? bus.req1_b  : bus.req0_b;
      accept    = (state_q == IDLE) && (gnt != 2'b00);
`ifdef ALU_ARB_OPCHK_EN
      illegal   = sel_op > 4'(OP_LAST);
`else
      illegal   = 1'b0;
`endif
      resp_take = (state_q == RESP) && (g_q ? bus.resp1_ready : bus.resp0_ready);

      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = illegal ? RESP : EXEC;
         EXEC: state_d = RESP;
         RESP: if (resp_take) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         prio_q    <= 1'b0;
         g_q       <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_y_q   <= '0;
         res_flg_q <= 1'b0;
         res_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            g_q       <= gnt_idx;
            res_err_q <= illegal;
            // Rejected opcodes leave the ALU bus untouched and return a zero result.
            if (illegal) begin
               res_y_q   <= '0;
               res_flg_q <= 1'b0;
            end else begin
               op_q <= sel_op;
               a_q  <= sel_a;
               b_q  <= sel_b;
            end
         end
         if (state_q == EXEC) begin
            res_y_q   <= bus.alu_y;
            res_flg_q <= bus.alu_flg;
         end
         if (resp_take) begin
            prio_q <= ~g_q;
         end
      end
   end

   assign bus.req0_ready  = (state_q == IDLE) && gnt[0];
   assign bus.req1_ready  = (state_q == IDLE) && gnt[1];

   assign bus.resp0_valid = (state_q == RESP) && !g_q;
   assign bus.resp1_valid = (state_q == RESP) &&  g_q;
   assign bus.resp0_y     = res_y_q;
   assign bus.resp1_y     = res_y_q;
   assign bus.resp0_flg   = res_flg_q;
   assign bus.resp1_flg   = res_flg_q;
   assign bus.resp0_err   = res_err_q;
   assign bus.resp1_err   = res_err_q;

   assign bus.alu_op      = op_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written contention,
// backpressure and reset sequences, then random traffic against a model.
module tb_alu_arbiter;

`ifdef ALU_ARB_OPCHK_EN
   localparam bit OPCHK = 1'b1;
`else
   localparam bit OPCHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if #(.N(8)) bus ();

   alu_arbiter #(.N(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic       rq_v  [2];
   logic [3:0] rq_op [2];
   logic [7:0] rq_a  [2];
   logic [7:0] rq_b  [2];
   logic       rs_r  [2];

   assign bus.req0_valid  = rq_v[0];
   assign bus.req0_op     = rq_op[0];
   assign bus.req0_a      = rq_a[0];
   assign bus.req0_b      = rq_b[0];
   assign bus.req1_valid  = rq_v[1];
   assign bus.req1_op     = rq_op[1];
   assign bus.req1_a      = rq_a[1];
   assign bus.req1_b      = rq_b[1];
   assign bus.resp0_ready = rs_r[0];
   assign bus.resp1_ready = rs_r[1];

   // Shared ALU: plain arithmetic, flag is (a-b)==0, opcodes 8..15 give y=0.
   function automatic logic [8:0] alu_fn(logic [3:0] op, logic [7:0] a, logic [7:0] b);
      logic [7:0] y;
      logic signed [7:0] sa;
      sa = a;
      case (op)
         4'd0: y = a + b;
         4'd1: y = a - b;
         4'd2: y = a & b;
         4'd3: y = a | b;
         4'd4: y = a ^ b;
         4'd5: y = a << b;
         4'd6: y = a >> b;
         4'd7: y = $unsigned(sa >>> b);
         default: y = 8'h00;
      endcase
      return {(8'(a - b) == 8'h00), y};
   endfunction

   always_comb {bus.alu_flg, bus.alu_y} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rdy(int i);  return i != 0 ? bus.req1_ready  : bus.req0_ready;  endfunction
   function automatic logic rv(int i);   return i != 0 ? bus.resp1_valid : bus.resp0_valid; endfunction
   function automatic logic [7:0] ry(int i); return i != 0 ? bus.resp1_y : bus.resp0_y;     endfunction
   function automatic logic rf(int i);   return i != 0 ? bus.resp1_flg   : bus.resp0_flg;   endfunction
   function automatic logic re(int i);   return i != 0 ? bus.resp1_err   : bus.resp0_err;   endfunction

   task automatic step(); @(posedge clk); #1; endtask
   task automatic smp();  @(negedge clk);     endtask

   typedef struct {
      int         w;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic       flg;
      logic       err;
   } vec_t;

   vec_t tbl[10];
   logic [3:0] last_op;
   logic [7:0] last_a, last_b;

   task automatic run_vec(input vec_t v);
      rq_op[v.w] = v.op; rq_a[v.w] = v.a; rq_b[v.w] = v.b; rq_v[v.w] = 1'b1;
      rs_r[0] = 1'b1; rs_r[1] = 1'b1;
      smp();
      chk("vec_ready_win", 32'(rdy(v.w)), 32'd1);
      chk("vec_ready_other", 32'(rdy(1 - v.w)), 32'd0);
      step();
      rq_v[v.w] = 1'b0;
      if (!v.err) begin
         last_op = v.op; last_a = v.a; last_b = v.b;
         smp();
         chk("vec_exec_busy", 32'(bus.busy), 32'd1);
         chk("vec_exec_valid", 32'(rv(v.w)), 32'd0);
         chk("vec_alu_a", 32'(bus.alu_a), 32'(v.a));
         chk("vec_alu_b", 32'(bus.alu_b), 32'(v.b));
         step();
      end
      smp();
      chk("vec_resp_valid", 32'(rv(v.w)), 32'd1);
      chk("vec_resp_other", 32'(rv(1 - v.w)), 32'd0);
      chk("vec_y", 32'(ry(v.w)), 32'(v.y));
      chk("vec_flg", 32'(rf(v.w)), 32'(v.flg));
      chk("vec_err", 32'(re(v.w)), 32'(v.err));
      chk("vec_alu_op", 32'(bus.alu_op), 32'(last_op));
      step();
      smp();
      chk("vec_done_valid", 32'(rv(v.w)), 32'd0);
      chk("vec_done_busy", 32'(bus.busy), 32'd0);
      step();
   endtask

   // Transaction-level reference for random traffic.
   bit         m_busy;
   int         m_g, m_left, m_prio;
   logic [3:0] m_op;
   logic [7:0] m_a, m_b, m_y;
   logic       m_flg, m_err;

   initial begin
      automatic vec_t v;
      automatic bit acc[2];
      automatic bit e_rdy[2];
      automatic logic [8:0] r;
      automatic bit ill;

      for (int i = 0; i < 2; i++) begin
         rq_v[i] = 1'b0; rq_op[i] = 4'h0; rq_a[i] = 8'h00; rq_b[i] = 8'h00; rs_r[i] = 1'b1;
      end
      last_op = 4'h0; last_a = 8'h00; last_b = 8'h00;

      tbl[0] = '{w:0, op:4'h0, a:8'h05, b:8'h03, y:8'h08, flg:1'b0, err:1'b0};
      tbl[1] = '{w:1, op:4'h1, a:8'h07, b:8'h07, y:8'h00, flg:1'b1, err:1'b0};
      tbl[2] = '{w:0, op:4'h2, a:8'hF0, b:8'h3C, y:8'h30, flg:1'b0, err:1'b0};
      tbl[3] = '{w:1, op:4'h3, a:8'hF0, b:8'h0C, y:8'hFC, flg:1'b0, err:1'b0};
      tbl[4] = '{w:0, op:4'h4, a:8'hF0, b:8'h3C, y:8'hCC, flg:1'b0, err:1'b0};
      tbl[5] = '{w:1, op:4'h5, a:8'h81, b:8'h02, y:8'h04, flg:1'b0, err:1'b0};
      tbl[6] = '{w:0, op:4'h6, a:8'h81, b:8'h02, y:8'h20, flg:1'b0, err:1'b0};
      tbl[7] = '{w:1, op:4'h7, a:8'h81, b:8'h02, y:8'hE0, flg:1'b0, err:1'b0};
      if (OPCHK)
         tbl[8] = '{w:0, op:4'hA, a:8'h12, b:8'h12, y:8'h00, flg:1'b0, err:1'b1};
      else
         tbl[8] = '{w:0, op:4'hA, a:8'h12, b:8'h12, y:8'h00, flg:1'b1, err:1'b0};
      tbl[9] = '{w:1, op:4'h1, a:8'h03, b:8'h05, y:8'hFE, flg:1'b0, err:1'b0};

      // Reset values
      step(); step();
      rst = 1'b0;
      smp();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valids", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
      chk("rst_alu_bus", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
      chk("rst_resp", 32'({bus.resp0_y, bus.resp0_flg, bus.resp0_err}), 32'd0);
      chk("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      step();

      // Contention after reset: req0 wins, then req1
      rq_op[0] = 4'h1; rq_a[0] = 8'h07; rq_b[0] = 8'h07; rq_v[0] = 1'b1;
      rq_op[1] = 4'h4; rq_a[1] = 8'hF0; rq_b[1] = 8'h3C; rq_v[1] = 1'b1;
      smp();
      chk("cont_ready0", 32'(bus.req0_ready), 32'd1);
      chk("cont_ready1", 32'(bus.req1_ready), 32'd0);
      step(); rq_v[0] = 1'b0;
      smp(); chk("cont_exec_ready1", 32'(bus.req1_ready), 32'd0);
      step();
      smp();
      chk("cont_resp0_valid", 32'(bus.resp0_valid), 32'd1);
      chk("cont_resp0_y", 32'(bus.resp0_y), 32'h00);
      chk("cont_resp0_flg", 32'(bus.resp0_flg), 32'd1);
      chk("cont_resp1_idle", 32'(bus.resp1_valid), 32'd0);
      chk("cont_resp_ready1", 32'(bus.req1_ready), 32'd0);
      step();
      smp();
      chk("cont_resp0_drop", 32'(bus.resp0_valid), 32'd0);
      chk("cont_ready1_next", 32'(bus.req1_ready), 32'd1);
      step(); rq_v[1] = 1'b0;
      smp(); step();
      smp();
      chk("cont_resp1_valid", 32'(bus.resp1_valid), 32'd1);
      chk("cont_resp1_y", 32'(bus.resp1_y), 32'hCC);
      chk("cont_resp1_flg", 32'(bus.resp1_flg), 32'd0);
      step();

      // Third simultaneous pair goes to req0; req1 then held by backpressure
      rq_op[0] = 4'h2; rq_a[0] = 8'hFF; rq_b[0] = 8'h0F; rq_v[0] = 1'b1;
      rq_op[1] = 4'h5; rq_a[1] = 8'h81; rq_b[1] = 8'h02; rq_v[1] = 1'b1;
      rs_r[1] = 1'b0;
      smp();
      chk("pair3_ready0", 32'(bus.req0_ready), 32'd1);
      chk("pair3_ready1", 32'(bus.req1_ready), 32'd0);
      step(); rq_v[0] = 1'b0;
      smp(); step();
      smp();
      chk("pair3_resp0_y", 32'(bus.resp0_y), 32'h0F);
      step();
      rq_op[0] = 4'h0; rq_a[0] = 8'h01; rq_b[0] = 8'h01; rq_v[0] = 1'b1;
      smp();
      chk("bp_ready1", 32'(bus.req1_ready), 32'd1);
      chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
      step(); rq_v[1] = 1'b0;
      smp(); chk("bp_exec_ready0", 32'(bus.req0_ready), 32'd0);
      step();
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("bp_resp1_valid", 32'(bus.resp1_valid), 32'd1);
         chk("bp_resp1_y", 32'(bus.resp1_y), 32'h04);
         chk("bp_ready0_hold", 32'(bus.req0_ready), 32'd0);
         chk("bp_busy", 32'(bus.busy), 32'd1);
         step();
      end
      rs_r[1] = 1'b1;
      smp(); chk("bp_resp1_last", 32'(bus.resp1_valid), 32'd1);
      step();
      smp();
      chk("bp_resp1_drop", 32'(bus.resp1_valid), 32'd0);
      chk("bp_ready0_now", 32'(bus.req0_ready), 32'd1);
      step(); rq_v[0] = 1'b0;
      smp(); step();
      smp();
      chk("bp_resp0_y", 32'(bus.resp0_y), 32'h02);
      chk("bp_resp0_flg", 32'(bus.resp0_flg), 32'd1);
      step();

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         v = tbl[i];
         run_vec(v);
      end

      // Bus holds last legal operands while idle
      for (int k = 0; k < 10; k++) begin
         smp();
         chk("hold_op", 32'(bus.alu_op), 32'(last_op));
         chk("hold_ab", 32'({bus.alu_a, bus.alu_b}), 32'({last_a, last_b}));
         chk("hold_busy", 32'(bus.busy), 32'd0);
         step();
      end

      // Reset during EXEC drops the operation
      rq_op[0] = 4'h0; rq_a[0] = 8'h11; rq_b[0] = 8'h22; rq_v[0] = 1'b1;
      smp(); chk("rexec_ready0", 32'(bus.req0_ready), 32'd1);
      step(); rq_v[0] = 1'b0;
      smp(); chk("rexec_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      step(); rst = 1'b0;
      smp();
      chk("rexec_busy_clr", 32'(bus.busy), 32'd0);
      chk("rexec_alu_bus", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("rexec_no_resp", 32'({bus.resp0_valid, bus.resp1_valid}), 32'd0);
         step(); smp();
      end
      step();

      // Random traffic against the transaction model
      m_busy = 1'b0; m_g = 0; m_left = 0; m_prio = 0;
      m_op = 4'h0; m_a = 8'h00; m_b = 8'h00; m_y = 8'h00; m_flg = 1'b0; m_err = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         smp();
         acc[0] = 1'b0; acc[1] = 1'b0;
         for (int i = 0; i < 2; i++)
            e_rdy[i] = !m_busy && rq_v[i] && (!rq_v[1 - i] || m_prio == i);
         for (int i = 0; i < 2; i++) begin
            chk("rnd_ready", 32'(rdy(i)), 32'(e_rdy[i]));
            chk("rnd_resp_valid", 32'(rv(i)), 32'(m_busy && m_left == 0 && m_g == i));
         end
         chk("rnd_busy", 32'(bus.busy), 32'(m_busy));
         chk("rnd_alu_bus", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({m_op, m_a, m_b}));
         if (m_busy && m_left == 0)
            chk("rnd_result", 32'({ry(m_g), rf(m_g), re(m_g)}), 32'({m_y, m_flg, m_err}));

         if (m_busy) begin
            if (m_left > 0) m_left--;
            else if (rs_r[m_g]) begin
               m_busy = 1'b0;
               m_prio = 1 - m_g;
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (e_rdy[i]) begin
                  acc[i] = 1'b1;
                  ill = OPCHK && (rq_op[i] > 4'd7);
                  m_busy = 1'b1; m_g = i; m_left = ill ? 0 : 1;
                  m_err = ill;
                  if (ill) begin
                     m_y = 8'h00; m_flg = 1'b0;
                  end else begin
                     m_op = rq_op[i]; m_a = rq_a[i]; m_b = rq_b[i];
                     r = alu_fn(rq_op[i], rq_a[i], rq_b[i]);
                     m_y = r[7:0]; m_flg = r[8];
                  end
               end
            end
         end

         step();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) rq_v[i] = 1'b0;
            if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
               rq_op[i] = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                      : 4'($urandom_range(0, 7));
               rq_a[i]  = 8'($urandom_range(0, 255));
               rq_b[i]  = ($urandom_range(0, 4) == 0) ? rq_a[i] : 8'($urandom_range(0, 255));
               rq_v[i]  = 1'b1;
            end
            rs_r[i] = ($urandom_range(0, 3) != 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
